// File: rtl/oclib_pkg.sv
// Shared types and helpers for the oclib reset blocks.
package oclib_pkg;

  typedef enum logic [1:0] {
    RsqAssert,
    RsqRelease,
    RsqRun
  } reset_seq_state_e;

  // Larger of two integers; used to size counters shared by two timers.
  function automatic int oclib_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/oclib_reset_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after SyncCycles
// clock edges so the released reset is aligned to clock.
module oclib_reset_sync #(
  parameter int SyncCycles = 3
) (
  input  logic clock,
  input  logic reset_in,
  output logic reset_out
);

  (* dont_touch = "true", ASYNC_REG = "TRUE" *)
  logic [SyncCycles-1:0] sync_q;
  logic [SyncCycles-1:0] sync_d;

  // Shift zeros in once the incoming reset has dropped.
  always_comb begin
    sync_d = {sync_q[SyncCycles-2:0], 1'b0};
  end

  // Chain register: forced to all ones the instant reset rises.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign reset_out = sync_q[SyncCycles-1];

endmodule

// File: rtl/oclib_reset_sequencer.sv
// Ordered reset sequencer: holds all domain resets for a stretch period,
// then releases them one at a time from domain 0 upward with a fixed step.
// A software request re-runs the full sequence from the stretch phase.
module oclib_reset_sequencer
  import oclib_pkg::*;
#(
  parameter int Domains       = 4,
  parameter int StretchCycles = 16,
  parameter int StepCycles    = 8,
  parameter int SyncCycles    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               swResetReq,
  output logic [Domains-1:0] resetOut,
  output logic               busy,
  output logic               done
);

  localparam int MaxCycles = oclib_max(StretchCycles, StepCycles);
  localparam int CntW      = $clog2(MaxCycles + 1);
  localparam int IdxW      = $clog2(Domains + 1);

  localparam logic [CntW-1:0]    StretchLast = CntW'(StretchCycles - 1);
  localparam logic [CntW-1:0]    StepLast    = CntW'(StepCycles - 1);
  localparam logic [CntW-1:0]    CntMax      = '1;
  localparam logic [IdxW-1:0]    IdxAll      = IdxW'(Domains);
  localparam logic [Domains-1:0] AllOnes     = '1;

  logic rst_int;

  reset_seq_state_e   state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [Domains-1:0] reset_out_q, reset_out_d;
  logic [CntW-1:0]    cnt_inc;

  oclib_reset_sync #(
    .SyncCycles(SyncCycles)
  ) u_reset_sync (
    .clock    (clock),
    .reset_in (reset),
    .reset_out(rst_int)
  );

  // Saturating increment so a long-idle counter can never wrap to a match.
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

  // Next-state logic. Resets form a thermometer code, so releasing the
  // next domain is a left shift that clears the lowest still-set bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    reset_out_d = reset_out_q;

    if (swResetReq) begin
      // Re-assert everything at once; counting resumes when the request drops.
      state_d     = RsqAssert;
      cnt_d       = '0;
      idx_d       = '0;
      reset_out_d = AllOnes;
    end else begin
      case (state_q)
        RsqAssert: begin
          reset_out_d = AllOnes;
          if (cnt_q == StretchLast) begin
            state_d     = RsqRelease;
            reset_out_d = AllOnes << 1;
            idx_d       = IdxW'(1);
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RsqRelease: begin
          if (idx_q == IdxAll) begin
            // Last domain was released on the previous edge.
            state_d = RsqRun;
          end else if (cnt_q == StepLast) begin
            reset_out_d = reset_out_q << 1;
            idx_d       = idx_q + IdxW'(1);
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RsqRun: begin
          state_d = RsqRun;
        end
        default: begin
          state_d     = RsqAssert;
          cnt_d       = '0;
          idx_d       = '0;
          reset_out_d = AllOnes;
        end
      endcase
    end
  end

  // State registers; the synchronized reset clears them asynchronously.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      state_q     <= RsqAssert;
      cnt_q       <= '0;
      idx_q       <= '0;
      reset_out_q <= AllOnes;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      reset_out_q <= reset_out_d;
    end
  end

  assign resetOut = reset_out_q;
  assign busy     = (state_q != RsqRun);
  assign done     = (state_q == RsqRun);

endmodule

// File: tb/tb_oclib_reset_sequencer.sv
// Testbench for oclib_reset_sequencer: two instances (3-domain and
// 1-domain) share clock, reset and request; a timing model predicts the
// outputs and a monitor checks them against a scoreboard queue.
module tb_oclib_reset_sequencer;
  import oclib_pkg::*;

  localparam int D3 = 3, S3 = 4, P3 = 2;
  localparam int D1 = 1, S1 = 1, P1 = 1;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst;
  logic req;
  logic [2:0] out3;
  logic busy3, done3;
  logic [0:0] out1;
  logic busy1, done1;

  always #5 clk = ~clk;

  oclib_reset_sequencer #(
    .Domains(D3), .StretchCycles(S3), .StepCycles(P3), .SyncCycles(SYNC)
  ) u_dut3 (
    .clock(clk), .reset(rst), .swResetReq(req),
    .resetOut(out3), .busy(busy3), .done(done3)
  );

  oclib_reset_sequencer #(
    .Domains(D1), .StretchCycles(S1), .StepCycles(P1), .SyncCycles(SYNC)
  ) u_dut1 (
    .clock(clk), .reset(rst), .swResetReq(req),
    .resetOut(out1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [2:0] o3;
    logic       d3;
    logic       o1;
    logic       d1;
    int         n;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int n_tx   = 0;

  // Model: "age" = FSM-active edges since the sequence (re)started.
  int age3, wait3, age1, wait1;

  // Domain i is held while age < stretch + i*step.
  function automatic logic [31:0] mdl_out(input int age, input int d, input int s, input int st);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < d; i++) v[i] = (age < s + i * st);
    return v;
  endfunction

  // done one edge after the last domain is released.
  function automatic logic mdl_done(input int age, input int d, input int s, input int st);
    return (age >= s + (d - 1) * st + 1);
  endfunction

  task automatic model_reset();
    age3 = 0; wait3 = SYNC;
    age1 = 0; wait1 = SYNC;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (wait3 > 0) wait3--; else if (req) age3 = 0; else if (age3 < 1000) age3++;
      if (wait1 > 0) wait1--; else if (req) age1 = 0; else if (age1 < 1000) age1++;
    end
  endtask

  function automatic logic [2:0] cur3();
    logic [31:0] v;
    v = mdl_out(age3, D3, S3, P3);
    return v[2:0];
  endfunction

  task automatic push_exp();
    exp_t e;
    logic [31:0] v;
    e.o3 = cur3();
    e.d3 = mdl_done(age3, D3, S3, P3);
    v    = mdl_out(age1, D1, S1, P1);
    e.o1 = v[0];
    e.d1 = mdl_done(age1, D1, S1, P1);
    e.n  = n_tx;
    n_tx++;
    sb_q.push_back(e);
  endtask

  // One clock: model the edge, then change inputs between edges.
  task automatic step(input logic r, input logic q);
    @(posedge clk);
    model_edge();
    #2;
    rst = r;
    req = q;
    if (r) model_reset();
    push_exp();
  endtask

  // Short reset pulse entirely between two clock edges.
  task automatic step_pulse(input logic q);
    @(posedge clk);
    model_edge();
    #2;
    rst = 1'b1;
    req = q;
    model_reset();
    #2;
    rst = 1'b0;
    push_exp();
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tx=%0d got=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  // Monitor: every sample point, pop the prediction and compare.
  always @(negedge clk) begin
    exp_t e;
    logic inv;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty t=%0t got=none expected=entry", $time);
    end else begin
      e = sb_q.pop_front();
      $display("tx %0d rst=%0b req=%0b out3=%b done3=%0b out1=%b done1=%0b",
               e.n, rst, req, out3, done3, out1, done1);
      chk("out3",  e.n, {29'b0, out3},  {29'b0, e.o3});
      chk("done3", e.n, {31'b0, done3}, {31'b0, e.d3});
      chk("busy3", e.n, {31'b0, busy3}, {31'b0, ~e.d3});
      chk("out1",  e.n, {31'b0, out1},  {31'b0, e.o1});
      chk("done1", e.n, {31'b0, done1}, {31'b0, e.d1});
      chk("busy1", e.n, {31'b0, busy1}, {31'b0, ~e.d1});
      inv = (out3 == 3'b111) || (out3 == 3'b110) || (out3 == 3'b100) || (out3 == 3'b000);
      chk("order3", e.n, {31'b0, inv}, 32'd1);
      inv = (done3 == ((out3 == 3'b000) && (u_dut3.state_q == RsqRun)));
      chk("done_state3", e.n, {31'b0, inv}, 32'd1);
      inv = (done1 == ((out1 == 1'b0) && (u_dut1.state_q == RsqRun)));
      chk("done_state1", e.n, {31'b0, inv}, 32'd1);
    end
  end

  initial begin
    rst = 1'b1;
    req = 1'b0;
    model_reset();

    // Power-up: reset held for 5 cycles, then full sequence.
    repeat (5) step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);

    // One-cycle software request from RUN.
    step(1'b0, 1'b1);
    repeat (16) step(1'b0, 1'b0);

    // Request held 10 cycles starting once domain 0 is released.
    step(1'b0, 1'b1);
    for (int i = 0; i < 40 && cur3() != 3'b110; i++) step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);

    // Asynchronous reset pulse in the middle of the release phase.
    step(1'b0, 1'b1);
    for (int i = 0; i < 40 && cur3() != 3'b100; i++) step(1'b0, 1'b0);
    step_pulse(1'b0);
    repeat (20) step(1'b0, 1'b0);

    // Random request / reset stress.
    for (int i = 0; i < 600; i++) begin
      logic r, q;
      r = (rst && ($urandom_range(0, 1) == 0)) || ($urandom_range(0, 59) == 0);
      q = (req && ($urandom_range(0, 2) != 0)) || ($urandom_range(0, 24) == 0);
      if (!r && $urandom_range(0, 49) == 0) step_pulse(q);
      else step(r, q);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
